// File: rtl/mac_tx_framer_if.sv
// Byte stream from the frame source into mac_tx_framer: one frame per in_last,
// a byte moves on every cycle where in_valid and in_ready are both high.
interface mac_tx_framer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, in_valid, in_last, input in_ready);
  modport slave  (input in_data, in_valid, in_last, output in_ready);
endinterface

// File: rtl/mac_tx_framer.sv
// Ethernet transmit framer: pads a frame to MIN_LEN, appends the CRC-32 FCS and
// hands a gap-free byte burst to the RGMII stage, then waits for it to go idle.
module mac_tx_framer #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514
) (
  input  logic           clock,
  input  logic           reset_n,
  mac_tx_framer_if.slave up,
  input  logic           tx_active,
  output logic [7:0]     data,
  output logic           tx_enable,
  output logic           err_underrun,
  output logic           err_oversize
);

  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD, S_FCS, S_DROP, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [10:0] count, cnt_inc;
  logic [31:0] crc;
  logic [2:0]  fcs_cnt;
  logic        bad;

  logic        ready, accept, pad_more, pad_now, fcs_pending;
  logic [7:0]  crc_sel, fcs_byte;

  logic        emit, crc_upd, cnt_step, fcs_step, set_bad, pulse_u, pulse_o, clear;
  logic [7:0]  emit_byte;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  assign ready       = (state == S_DATA) || (state == S_DROP) ||
                       ((state == S_IDLE) && !tx_active);
  assign accept      = up.in_valid && ready;
  // Forced low while reset is held so every output reads 0 during reset.
  assign up.in_ready = ready && reset_n;

  assign cnt_inc     = (count >= MAX_L) ? count : count + 11'd1;
  assign fcs_pending = !fcs_cnt[2];
  assign crc_sel     = crc[{fcs_cnt[1:0], 3'b000} +: 8];
  // A good FCS is the complemented CRC register; a corrupted one is the raw register.
  assign fcs_byte    = bad ? crc_sel : ~crc_sel;

  if (MIN_LEN > 0) begin : g_pad
    assign pad_more = cnt_inc < 11'(MIN_LEN);
    assign pad_now  = count < 11'(MIN_LEN);
  end else begin : g_no_pad
    assign pad_more = 1'b0;
    assign pad_now  = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DATA: begin
        if (accept) begin
          if (up.in_last)         state_nxt = pad_more ? S_PAD : S_FCS;
          else if (cnt_inc == MAX_L) state_nxt = S_DROP;
          else                    state_nxt = S_DATA;
        end else if (state == S_DATA) begin
          state_nxt = (pad_now && pad_more) ? S_PAD : S_FCS;
        end
      end
      S_PAD:   if (!pad_more) state_nxt = S_FCS;
      S_FCS:   if (fcs_cnt == 3'd3) state_nxt = S_WAIT;
      S_DROP:  if (accept && up.in_last) state_nxt = (fcs_cnt < 3'd3) ? S_FCS : S_WAIT;
      S_WAIT:  if (!tx_active) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    emit      = 1'b0;
    emit_byte = 8'h00;
    crc_upd   = 1'b0;
    cnt_step  = 1'b0;
    fcs_step  = 1'b0;
    set_bad   = 1'b0;
    pulse_u   = 1'b0;
    pulse_o   = 1'b0;
    clear     = 1'b0;
    case (state)
      S_IDLE, S_DATA: begin
        if (accept) begin
          emit      = 1'b1;
          emit_byte = up.in_data;
          crc_upd   = 1'b1;
          cnt_step  = 1'b1;
          if (!up.in_last && cnt_inc == MAX_L) begin
            set_bad = 1'b1;
            pulse_o = 1'b1;
          end
        end else if (state == S_DATA) begin
          // Underrun: keep the burst going with a pad byte or the first
          // (already corrupted) FCS byte in this very cycle.
          emit    = 1'b1;
          set_bad = 1'b1;
          pulse_u = 1'b1;
          if (pad_now) begin
            crc_upd  = 1'b1;
            cnt_step = 1'b1;
          end else begin
            emit_byte = crc_sel;
            fcs_step  = 1'b1;
          end
        end
      end
      S_PAD: begin
        emit     = 1'b1;
        crc_upd  = 1'b1;
        cnt_step = 1'b1;
      end
      S_FCS: begin
        emit      = 1'b1;
        emit_byte = fcs_byte;
        fcs_step  = 1'b1;
      end
      S_DROP: begin
        if (fcs_pending) begin
          emit      = 1'b1;
          emit_byte = fcs_byte;
          fcs_step  = 1'b1;
        end
      end
      S_WAIT:  clear = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data         <= 8'h00;
      tx_enable    <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
      crc          <= CRC_INIT;
      count        <= 11'd0;
      fcs_cnt      <= 3'd0;
      bad          <= 1'b0;
    end else begin
      data         <= emit_byte;
      tx_enable    <= emit;
      err_underrun <= pulse_u;
      err_oversize <= pulse_o;
      if (clear) begin
        crc     <= CRC_INIT;
        count   <= 11'd0;
        fcs_cnt <= 3'd0;
        bad     <= 1'b0;
      end else begin
        if (crc_upd)  crc     <= crc32_byte(crc, emit_byte);
        if (cnt_step) count   <= cnt_inc;
        if (fcs_step) fcs_cnt <= fcs_cnt + 3'd1;
        if (set_bad)  bad     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Scoreboard bench for mac_tx_framer: stimulus queues the expected burst bytes,
// a negedge monitor pops and compares them and tracks burst length and errors.
module tb_mac_tx_framer;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #4 clock = ~clock;

  mac_tx_framer_if if0 ();
  mac_tx_framer_if if1 ();

  logic [7:0] s_data  = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last  = 1'b0;
  logic       sel     = 1'b1;
  logic       tx_active = 1'b0;

  logic [7:0] d0_data, d1_data;
  logic       d0_en, d1_en, d0_eu, d1_eu, d0_eo, d1_eo;

  assign if0.in_data  = s_data;
  assign if0.in_valid = s_valid && !sel;
  assign if0.in_last  = s_last;
  assign if1.in_data  = s_data;
  assign if1.in_valid = s_valid && sel;
  assign if1.in_last  = s_last;

  mac_tx_framer #(.MIN_LEN(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .up(if0), .tx_active(tx_active),
    .data(d0_data), .tx_enable(d0_en), .err_underrun(d0_eu), .err_oversize(d0_eo));

  mac_tx_framer dut1 (
    .clock(clock), .reset_n(reset_n), .up(if1), .tx_active(tx_active),
    .data(d1_data), .tx_enable(d1_en), .err_underrun(d1_eu), .err_oversize(d1_eo));

  logic [7:0] m_data;
  logic       m_en, m_eu, m_eo, m_ready;
  assign m_data  = sel ? d1_data : d0_data;
  assign m_en    = sel ? d1_en   : d0_en;
  assign m_eu    = sel ? d1_eu   : d0_eu;
  assign m_eo    = sel ? d1_eo   : d0_eo;
  assign m_ready = sel ? if1.in_ready : if0.in_ready;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0, n_miss = 0;
  int         frames_done = 0, frame_len = 0, byte_idx = 0;
  int         n_under = 0, n_over = 0, over_at = 0;
  bit         in_frame = 1'b0;
  int         tail_len = 2;
  int         first_wait = 0, stalls = 0;
  logic [7:0] frame_buf [1600];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-serial reference CRC-32 (reflected), one data bit at a time.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB8_8320;
    end
    return c;
  endfunction

  // RGMII-stage model: active while tx_enable is high and tail_len cycles after.
  initial begin
    int tail;
    tail = 0;
    forever begin
      @(posedge clock);
      #1;
      if (m_en)          tail = tail_len;
      else if (tail > 0) tail--;
      tx_active = m_en || (tail > 0);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        in_frame = 1'b0;
      end else begin
        if (in_frame) check("tx_enable_gap", m_en, 1);
        if (m_en) begin
          if (!in_frame) byte_idx = 0;
          if (exp_q.size() == 0) begin
            check("tx_enable_unexpected", m_en, 0);
          end else begin
            e = exp_q.pop_front();
            byte_idx++;
            check("tx_data", m_data, e.data);
            in_frame = !e.last;
            if (e.last) begin
              frame_len = byte_idx;
              frames_done++;
            end
          end
        end
        if (m_eu) n_under++;
        if (m_eo) begin
          n_over++;
          over_at = byte_idx;
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input bit last);
    exp_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic queue_frame(input int len, input int min_len, input bit corrupt);
    logic [31:0] c;
    logic [7:0]  b;
    int          total;
    c     = 32'hFFFF_FFFF;
    total = (len > min_len) ? len : min_len;
    for (int i = 0; i < total; i++) begin
      b = (i < len) ? frame_buf[i] : 8'h00;
      c = crc_step(c, b);
      push_exp(b, 1'b0);
    end
    c = ~c;
    if (corrupt) c = ~c;
    for (int k = 0; k < 4; k++) push_exp(c[8*k +: 8], k == 3);
  endtask

  task automatic fill_buf(input int seed);
    for (int i = 0; i < 1600; i++) frame_buf[i] = 8'(i * 13 + seed);
  endtask

  // Called at a negedge; returns at the negedge after the last byte is taken.
  task automatic send_bytes(input int n, input bit with_last);
    int w;
    for (int i = 0; i < n; i++) begin
      s_data  = frame_buf[i];
      s_valid = 1'b1;
      s_last  = with_last && (i == n - 1);
      w = 0;
      while (!m_ready && w < 3000) begin
        @(negedge clock);
        w++;
      end
      if (w >= 3000) begin
        check("in_ready_timeout", m_ready, 1);
        break;
      end
      if (i == 0) begin
        first_wait = w;
        check("start_while_tx_active", tx_active, 0);
      end else begin
        stalls += w;
      end
      @(negedge clock);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int w;
    w = 0;
    while (frames_done < target && w < 5000) begin
      @(negedge clock);
      w++;
    end
    check("frames_done", frames_done, target);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #3;
    check("rst_tx_enable", m_en, 0);
    check("rst_data", m_data, 0);
    check("rst_in_ready", m_ready, 0);
    check("rst_err_underrun", m_eu, 0);
    check("rst_err_oversize", m_eo, 0);
    #20 reset_n = 1'b1;
    @(negedge clock);
    check("idle_in_ready", m_ready, 1);

    // 1: MIN_LEN=0, "123456789" -> known CRC-32 0xCBF43926.
    sel = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 9; i++) begin
      frame_buf[i] = 8'h31 + 8'(i);
      push_exp(frame_buf[i], 1'b0);
    end
    push_exp(8'h26, 1'b0);
    push_exp(8'h39, 1'b0);
    push_exp(8'hF4, 1'b0);
    push_exp(8'hCB, 1'b1);
    send_bytes(9, 1'b1);
    wait_frames(1);
    check("t1_burst_len", frame_len, 13);
    check("t1_underrun", n_under, 0);
    check("t1_oversize", n_over, 0);
    repeat (5) @(negedge clock);
    sel = 1'b1;
    repeat (5) @(negedge clock);

    // 2: one byte padded to 60.
    frame_buf[0] = 8'hAA;
    queue_frame(1, 60, 1'b0);
    send_bytes(1, 1'b1);
    wait_frames(2);
    check("t2_burst_len", frame_len, 64);
    check("t2_underrun", n_under, 0);

    // 3: underrun after 40 bytes -> pad to 60, inverted FCS.
    fill_buf(5);
    queue_frame(40, 60, 1'b1);
    send_bytes(40, 1'b0);
    wait_frames(3);
    check("t3_burst_len", frame_len, 64);
    check("t3_underrun_pulses", n_under, 1);
    check("t3_oversize", n_over, 0);

    // 4: 1600-byte input truncated at MAX_LEN.
    fill_buf(9);
    queue_frame(1514, 60, 1'b1);
    stalls = 0;
    send_bytes(1600, 1'b1);
    check("t4_in_ready_stalls", stalls, 0);
    wait_frames(4);
    check("t4_burst_len", frame_len, 1518);
    check("t4_oversize_pulses", n_over, 1);
    check("t4_oversize_at_byte", over_at, 1514);
    check("t4_underrun", n_under, 1);

    // 5: back-to-back frames with a long tx_active tail.
    tail_len = 20;
    fill_buf(17);
    queue_frame(64, 60, 1'b0);
    send_bytes(64, 1'b1);
    fill_buf(33);
    queue_frame(61, 60, 1'b0);
    send_bytes(61, 1'b1);
    check("t5_holdoff_ge_24", 32'(first_wait >= 24), 1);
    wait_frames(6);
    check("t5_burst_len", frame_len, 65);
    tail_len = 2;
    repeat (5) @(negedge clock);

    // 6: asynchronous reset mid-payload, then a fresh 60-byte frame.
    fill_buf(71);
    for (int i = 0; i < 30; i++) push_exp(frame_buf[i], 1'b0);
    send_bytes(30, 1'b0);
    check("t6_pre_reset_tx_enable", m_en, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_tx_enable", m_en, 0);
    check("t6_async_data", m_data, 0);
    check("t6_async_in_ready", m_ready, 0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    #3 reset_n = 1'b1;
    @(negedge clock);
    fill_buf(101);
    queue_frame(60, 60, 1'b0);
    send_bytes(60, 1'b1);
    wait_frames(7);
    check("t6_burst_len", frame_len, 64);
    check("t6_underrun", n_under, 1);
    check("t6_oversize", n_over, 1);

    repeat (5) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mac_tx_framer.md
Name: mac_tx_framer

Overview:
Sits directly upstream of the RGMII transmit stage and feeds its data/tx_enable inputs.
- Takes a byte stream holding one Ethernet frame (destination MAC through end of payload).
- Zero-pads the frame to the minimum length and appends the IEEE 802.3 FCS (CRC-32).
- Presents the result as a gap-free byte burst; the RGMII stage adds the preamble/SFD and the inter-frame gap.
- Holds off the next frame until the RGMII stage reports idle.

Parameters:
MIN_LEN, 60, minimum frame length in bytes before FCS; shorter frames are zero-padded. 0 disables padding.
MAX_LEN, 1514, maximum frame length in bytes before FCS; longer input is truncated and the frame is marked bad.

Ports:
clock  in  1  125 MHz transmit clock; same clock as the RGMII stage's clock output.
reset_n  in  1  asynchronous active-low reset.
in_data  in  8  frame byte from upstream.
in_valid  in  1  in_data valid.
in_last  in  1  marks the final byte of the frame.
in_ready  out  1  byte accepted when in_valid & in_ready.
tx_active  in  1  RGMII stage active output.
data  out  8  byte to the RGMII stage.
tx_enable  out  1  byte strobe to the RGMII stage; stays high for the whole frame.
err_underrun  out  1  one-cycle pulse on upstream underrun.
err_oversize  out  1  one-cycle pulse on MAX_LEN overflow.

Behaviour:
Reset:
- All outputs are 0, state IDLE, byte count 0, CRC 0xFFFFFFFF.
- Reset is asynchronous. If asserted mid-frame, tx_enable drops immediately and the partial frame is abandoned.

Outputs:
- data and tx_enable are registered, with 1-cycle latency from byte acceptance.
- The CRC covers every transmitted byte, including pad bytes.

States:
- IDLE
  - in_ready = !tx_active.
  - On acceptance: register the byte, set count=1, update the CRC. Go to DATA, or to PAD/FCS if in_last is set on this byte.
- DATA
  - in_ready = 1. Each accepted byte is sent and count increments.
  - in_last accepted: go to PAD if count+1 < MIN_LEN, else FCS.
  - in_valid low in DATA (underrun):
    - Pulse err_underrun, go to FCS.
    - Send the FCS bit-inverted, so the frame is deliberately corrupted.
    - tx_enable never gaps.
  - Count reaches MAX_LEN without in_last:
    - Pulse err_oversize, go to DROP; the FCS is inverted.
- DROP
  - in_ready = 1, in_valid bytes are discarded, FCS bytes are sent concurrently.
  - Remains until in_last is accepted; DROP may outlast the FCS.
  - The next state is WAIT only once both the FCS is done and in_last has been seen.
- PAD
  - in_ready = 0. Sends 0x00 until count = MIN_LEN, then goes to FCS.
- FCS
  - in_ready = 0 (except when DROP is pending).
  - Sends ~CRC in 4 bytes, least-significant byte first, then goes to WAIT.
- WAIT
  - tx_enable = 0, CRC reinitialised, count cleared.
  - Goes to IDLE on the first cycle tx_active = 0.

CRC and count:
- CRC-32 is reflected: polynomial 0xEDB88320, init 0xFFFFFFFF, LSB-first, one byte per cycle, final XOR 0xFFFFFFFF.
- The byte count is 11 bits and saturates at MAX_LEN.

Simultaneous events:
- in_last together with reaching MAX_LEN: treated as a normal end, not oversize.
- in_valid held high in WAIT or PAD: ignored, because in_ready = 0.
- A frame of exactly MIN_LEN bytes gets no padding.

Burst length:
- tx_enable high cycles = max(len, MIN_LEN) + 4, contiguous.

Test Plan:
1. MIN_LEN=0, send ASCII "123456789" contiguously -> 13 tx_enable cycles; last 4 data bytes are 0x26 0x39 0xF4 0xCB; no error pulses.
2. Default params, 1-byte frame 0xAA -> tx_enable high 64 contiguous cycles; bytes 2-60 are 0x00; the 4 FCS bytes match a software CRC-32 over the 60 bytes.
3. 100-byte frame with in_valid dropped after byte 40 -> err_underrun pulses once; 40 data bytes + 20 pad + 4 bytes equal to the bitwise inverse of the correct FCS; tx_enable never gaps.
4. 1600-byte frame -> err_oversize pulses at byte 1514; 1518 tx_enable cycles with inverted FCS; in_ready stays 1 until in_last; next frame is not started before tx_active=0.
5. Back-to-back frames with tx_active held high 20 cycles after the first burst -> in_ready stays 0 until tx_active falls; second frame CRC is correct, confirming the CRC reinitialised.
6. Assert reset_n low in mid-payload -> tx_enable, data and in_ready go to 0 without waiting for a clock edge; after release, a fresh 60-byte frame is sent with correct FCS.
